// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, the hard-wired zero register and the writeback request type.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin grant; the search starts at ptr and the pointer moves just past each winner.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);
    logic [PW-1:0] ptr;
    int j;
    // Walk offsets from farthest to nearest so the nearest requester from ptr wins.
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        j = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j] && reset) begin
                gnt = '0;
                gnt[j] = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end
    assign gnt_vld = |gnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr <= '0;
        else if (gnt_vld) ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the regfile write port with a one-entry registered write stage.
// Define WB_BYPASS_EN to add combinational read forwarding from the staged (not yet committed) write.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        ack_out,
    output logic                      wr_en_out,
    output logic [ADDR_W-1:0]         wr_reg_out,
    output logic [DATA_W-1:0]         wr_data_out,
    output logic                      busy_out
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         rd1_reg_in,
    input  logic [ADDR_W-1:0]         rd2_reg_in,
    input  logic [DATA_W-1:0]         rf_data1_in,
    input  logic [DATA_W-1:0]         rf_data2_in,
    output logic [DATA_W-1:0]         fwd_data1_out,
    output logic [DATA_W-1:0]         fwd_data2_out
`endif
);
    import regfile_pkg::*;
    localparam int PW = $clog2(NUM_REQ);
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
        $error("regfile_wb_arbiter: NUM_REQ must be within 2..8");
    end
    logic [PW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_in),
        .gnt     (ack_out),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );
    assign g_addr = addr_in[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign g_data = data_in[int'(gnt_idx)*DATA_W +: DATA_W];
    // Writes to register 0 are still acked and staged, but never enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_out   <= 1'b0;
            wr_reg_out  <= '0;
            wr_data_out <= '0;
        end else begin
            wr_en_out <= gnt_vld && (g_addr != ADDR_W'(REG_ZERO));
            if (gnt_vld) begin
                wr_reg_out  <= g_addr;
                wr_data_out <= g_data;
            end
        end
    end
    assign busy_out = (|req_in) || wr_en_out;
`ifdef WB_BYPASS_EN
    assign fwd_data1_out = (wr_en_out && rd1_reg_in == wr_reg_out) ? wr_data_out : rf_data1_in;
    assign fwd_data2_out = (wr_en_out && rd2_reg_in == wr_reg_out) ? wr_data_out : rf_data2_in;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table, hand sequences and randomized requesters against a reference model.
module tb_regfile_wb_arbiter;
    localparam int N = 3;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_in = '0;
    logic [14:0] addr_in = '0;
    logic [95:0] data_in = '0;
    logic [2:0]  ack_out;
    logic        wr_en_out;
    logic [4:0]  wr_reg_out;
    logic [31:0] wr_data_out;
    logic        busy_out;
`ifdef WB_BYPASS_EN
    logic [4:0]  rd1_reg_in = '0, rd2_reg_in = '0;
    logic [31:0] rf_data1_in = '0, rf_data2_in = '0;
    logic [31:0] fwd_data1_out, fwd_data2_out;
`endif
    int checks = 0;
    int errors = 0;
    int m_ptr;
    logic m_en;
    logic [4:0] m_reg;
    logic [31:0] m_data;
    int waits [N];

    typedef struct {
        logic [2:0]  req;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  ack;
        logic        en;
        logic [4:0]  rg;
        logic [31:0] dat;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .ack_out     (ack_out),
        .wr_en_out   (wr_en_out),
        .wr_reg_out  (wr_reg_out),
        .wr_data_out (wr_data_out),
        .busy_out    (busy_out)
`ifdef WB_BYPASS_EN
        ,
        .rd1_reg_in    (rd1_reg_in),
        .rd2_reg_in    (rd2_reg_in),
        .rf_data1_in   (rf_data1_in),
        .rf_data2_in   (rf_data2_in),
        .fwd_data1_out (fwd_data1_out),
        .fwd_data2_out (fwd_data2_out)
`endif
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int m_grant(input logic [2:0] r);
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_en = 1'b0;
        m_reg = '0;
        m_data = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    task automatic model_check();
        int g;
        logic [2:0] ea;
        g = m_grant(req_in);
        ea = '0;
        if (g >= 0) ea[g] = 1'b1;
        chk("ack", ack_out, ea);
        chk("wr_en", wr_en_out, m_en);
        chk("wr_reg", wr_reg_out, m_reg);
        chk("wr_data", wr_data_out, m_data);
        chk("busy", busy_out, (|req_in) || m_en);
    endtask

    task automatic model_tick();
        int g;
        logic [4:0] a;
        g = m_grant(req_in);
        if (g >= 0) begin
            a = addr_in[g*5 +: 5];
            m_en = (a != 5'd0);
            m_reg = a;
            m_data = data_in[g*32 +: 32];
            m_ptr = (g + 1) % N;
        end else begin
            m_en = 1'b0;
        end
    endtask

    task automatic cycle_in(input logic [2:0] r, input logic [14:0] a, input logic [95:0] d);
        @(posedge clk);
        #1;
        req_in = r;
        addr_in = a;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [2:0] exp_ack [4];
        logic exp_en [4];
        logic [2:0] nr;
        logic [14:0] na;
        logic [95:0] nd;
        int g;
        tbl[0] = '{3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 3'b010, 1'b0, 5'd0, 32'd0};
        tbl[1] = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd7, 32'hDEADBEEF};
        tbl[2] = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd7, 32'hDEADBEEF};
        tbl[3] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10}, 3'b100, 1'b0, 5'd7, 32'hDEADBEEF};
        tbl[4] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10}, 3'b001, 1'b1, 5'd3, 32'd30};
        tbl[5] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10}, 3'b010, 1'b1, 5'd1, 32'd10};
        tbl[6] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10}, 3'b100, 1'b1, 5'd2, 32'd20};
        tbl[7] = '{3'b001, 15'd0, {64'd0, 32'd5}, 3'b001, 1'b1, 5'd3, 32'd30};
        tbl[8] = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'd5};
        tbl[9] = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'd5};
        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_en = '{1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held with all requesting, then rotation from pointer 0.
        model_reset();
        req_in = 3'b111;
        addr_in = {5'd3, 5'd2, 5'd1};
        data_in = {32'd30, 32'd20, 32'd10};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ack", ack_out, 3'b000);
            chk("rst_wr_en", wr_en_out, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rot_ack%0d", c), ack_out, exp_ack[c]);
            chk($sformatf("rot_en%0d", c), wr_en_out, exp_en[c]);
            model_check();
            model_tick();
        end

        // Asynchronous reset mid-cycle while a write is staged.
        #2;
        reset = 1'b0;
        req_in = 3'b101;
        #1;
        chk("async_wr_en", wr_en_out, 1'b0);
        chk("async_wr_reg", wr_reg_out, 5'd0);
        chk("async_ack", ack_out, 3'b000);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ptr_after_rst", ack_out, 3'b001);
        model_check();
        model_tick();

        do_reset();
        foreach (tbl[i]) begin
            cycle_in(tbl[i].req, tbl[i].addr, tbl[i].data);
            chk($sformatf("vec%0d_ack", i), ack_out, tbl[i].ack);
            chk($sformatf("vec%0d_en", i), wr_en_out, tbl[i].en);
            chk($sformatf("vec%0d_reg", i), wr_reg_out, tbl[i].rg);
            chk($sformatf("vec%0d_data", i), wr_data_out, tbl[i].dat);
            model_tick();
        end

`ifdef WB_BYPASS_EN
        do_reset();
        cycle_in(3'b001, {10'd0, 5'd9}, {64'd0, 32'h1234});
        model_check();
        model_tick();
        cycle_in(3'b000, 15'd0, 96'd0);
        model_check();
        rd1_reg_in = 5'd9;
        rf_data1_in = 32'h0;
        #1;
        chk("fwd1_hit", fwd_data1_out, 32'h1234);
        rd1_reg_in = 5'd10;
        rf_data1_in = 32'h5555;
        #1;
        chk("fwd1_miss", fwd_data1_out, 32'h5555);
        rd2_reg_in = 5'd9;
        rf_data2_in = 32'h7;
        #1;
        chk("fwd2_hit", fwd_data2_out, 32'h1234);
        model_tick();
        cycle_in(3'b000, 15'd0, 96'd0);
        chk("fwd2_idle", fwd_data2_out, 32'h7);
        model_check();
        model_tick();
`endif

        // Randomized requesters that hold each write until acked.
        for (int i = 0; i < N; i++) waits[i] = 0;
        nr = '0;
        na = '0;
        nd = '0;
        for (int c = 0; c < 400; c++) begin
            cycle_in(nr, na, nd);
            g = m_grant(req_in);
            for (int i = 0; i < N; i++) if (req_in[i]) waits[i]++;
            if (g >= 0) begin
                checks++;
                if (waits[g] > N) begin
                    errors++;
                    $display("FAIL fair req%0d waited %0d cycles limit %0d", g, waits[g], N);
                end
                waits[g] = 0;
            end
            model_check();
            model_tick();
            for (int i = 0; i < N; i++) begin
                if (!(nr[i] && i != g)) begin
                    nr[i] = ($urandom_range(0, 2) != 0);
                    na[i*5 +: 5] = 5'($urandom_range(0, 31));
                    nd[i*32 +: 32] = $urandom;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback sources, such as the ALU, the load unit and the multiply/divide unit. Each cycle a round-robin arbiter picks one requesting source and acknowledges it. The winner's destination register and data are registered into a one-entry write stage that drives the regfile write port on the next cycle. The block sits between the execute/memory writeback sources and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (low = reset asserted)
req_in  in  NUM_REQ  bit i: requester i has a pending write; held until acked
addr_in  in  NUM_REQ*ADDR_W  slice i: requester i destination register
data_in  in  NUM_REQ*DATA_W  slice i: requester i write data
ack_out  out  NUM_REQ  one-hot or zero; combinational grant for the current cycle
wr_en_out  out  1  registered regfile write enable
wr_reg_out  out  ADDR_W  registered regfile write index
wr_data_out  out  DATA_W  registered regfile write data
busy_out  out  1  high when req_in has any bit set or wr_en_out is high

Behaviour:
- Reset (reset low, asynchronous): wr_en_out=0, wr_reg_out=0, wr_data_out=0, rr_ptr=0. ack_out=0 while reset is low.
- Arbitration (combinational):
  - Search req_in starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins, and only that bit of ack_out is set.
  - If req_in=0, ack_out=0.
- Requester handshake:
  - A requester holds req/addr/data stable until it sees ack high at a rising edge.
  - It deasserts req (or presents its next write) in the following cycle.
  - A requester whose req stays high after an ack is treated as issuing a new write.
- Round-robin pointer: on a clock edge with a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Write stage:
  - On every edge, wr_en_out <= (any grant) && (granted addr != 0), and wr_reg_out/wr_data_out <= the granted slices.
  - With no grant, wr_en_out <= 0 and wr_reg_out/wr_data_out hold their previous values.
- Latency:
  - Grant in cycle N gives wr_en_out high for exactly cycle N+1.
  - The regfile commits the value at the end of cycle N+1.
  - Sustained throughput is one write per cycle.
- Register 0:
  - A write to register 0 is acked normally (the requester is not stalled).
  - wr_en_out stays 0, so no regfile write occurs.
- Same destination: two requesters targeting the same register are serialised in grant order; the later grant's data wins.
- Fairness: every requester holding req continuously is granted within NUM_REQ cycles.
- Reset mid-operation:
  - An in-flight staged write is dropped (wr_en_out forced to 0).
  - Requesters must reissue any write that was not acked before reset.
- Out-of-range: req_in bits above NUM_REQ-1 do not exist. Parameters outside 2..8 are a compile-time error (generate check).

Optional Feature:
Macro WB_BYPASS_EN.
- When defined, the block adds these ports:
  - rd1_reg_in, rd2_reg_in (ADDR_W): regfile read indices.
  - rf_data1_in, rf_data2_in (DATA_W): raw regfile read data.
  - fwd_data1_out, fwd_data2_out (DATA_W).
- fwd_dataK_out = wr_data_out when wr_en_out=1 and rdK_reg_in == wr_reg_out (this implies the index is non-zero); otherwise it equals rf_dataK_in. The path is purely combinational.
- This covers the cycle in which the staged write has not yet committed.
- When not defined, these ports are absent and consumers read the regfile directly, accepting a one-cycle read-after-write hazard that the pipeline must stall on.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W/ADDR_W constants.
  - REG_ZERO = 5'd0 localparam.
  - A wb_req_t typedef (addr, data).
- One natural sub-module, rr_arbiter: a NUM_REQ-wide round-robin grant with pointer update.
  - Reusable for memory-port sharing.
  - The write stage and bypass logic stay in the top module.

Test Plan:
1. Reset held low 3 cycles with req_in=3'b111 -> ack_out=0, wr_en_out=0. Release -> first ack_out=3'b001.
2. Single request: req_in=3'b010, addr1=5'd7, data1=32'hDEADBEEF -> ack_out=3'b010 in cycle N; in N+1, wr_en_out=1, wr_reg_out=7, wr_data_out=DEADBEEF; in N+2, wr_en_out=0.
3. All three requesting continuously from rr_ptr=0 -> acks 001,010,100,001 on consecutive cycles; wr_en_out high every cycle from the second onward.
4. req_in=3'b001, addr0=0, data0=32'h5 -> ack_out=3'b001, wr_en_out stays 0 next cycle.
5. Reset asserted asynchronously mid-cycle while wr_en_out=1 -> wr_en_out drops to 0 immediately without waiting for a clock edge; rr_ptr=0 after release.
6. (WB_BYPASS_EN) Staged write reg 9 = 32'h1234, rd1_reg_in=9, rf_data1_in=32'h0 -> fwd_data1_out=32'h1234. Same setup with rd1_reg_in=10 -> fwd_data1_out=rf_data1_in.
